sdram_arbiter: RTL and testbench

Two-port arbiter sharing the single `sdram` controller command interface (25-bit word address, 32-bit data, `rw`/`in_valid`/`busy`/`out_valid` handshake) between two requesters, e.g. `ram_test` and a second bus master. It accepts one request at a time and drives it into the controller. It then routes the returned read data back to the port that issued it. Sits directly between the requesters and `sdram`; `sdram` is unchanged.

---
 rtl/sdram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arbiter
//  Purpose  : Two-port arbiter in front of a single sdram controller command
//             interface. Grants one request at a time, holds the command
//             until the controller accepts it, and routes read data back to
//             the port that issued the read. A read that gets no data within
//             RD_TIMEOUT cycles sets a sticky timeout_err.
//  Options  : SDRAM_ARB_FIXED_PRIO_EN - port 0 always wins a tie
//             (default: round-robin)
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter int ADDR_W     = 25,
    parameter int DATA_W     = 32,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rw,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_valid,
    output logic              m0_ready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rvalid,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rw,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_valid,
    output logic              m1_ready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rvalid,
    output logic [ADDR_W-1:0] addr,
    output logic              rw,
    output logic [DATA_W-1:0] data_in,
    output logic              in_valid,
    input  logic              busy,
    input  logic [DATA_W-1:0] data_out,
    input  logic              out_valid,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    // Last RD_WAIT cycle in which returned data is still accepted.
    localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

    state_t      state;
    state_t      state_next;
    logic        owner;      // port that issued the outstanding command
    logic [15:0] tmo_cnt;    // RD_WAIT cycles elapsed so far
    logic        winner;     // port selected if a grant happens this cycle
    logic        grant;
    logic        accept;
    logic        rd_done;
    logic        rd_tmo;

`ifndef SDRAM_ARB_FIXED_PRIO_EN
    logic        last_grant;

    // Remember the most recently granted port; reset to 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (grant) begin
            last_grant <= winner;
        end
    end
`endif

    // Pick the winning port from the currently pending requests.
    always_comb begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
        winner = !m0_valid;
`else
        if (m0_valid && m1_valid) begin
            winner = !last_grant;
        end else begin
            winner = m1_valid;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and one-cycle event strobes for the datapath.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        accept     = 1'b0;
        rd_done    = 1'b0;
        rd_tmo     = 1'b0;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!busy) begin
                    accept     = 1'b1;
                    state_next = rw ? IDLE : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (out_valid) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    rd_tmo     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command, handshake and read-return registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr        <= '0;
            rw          <= 1'b0;
            data_in     <= '0;
            in_valid    <= 1'b0;
            owner       <= 1'b0;
            tmo_cnt     <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            m0_ready  <= 1'b0;
            m1_ready  <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (grant) begin
                addr     <= winner ? m1_addr  : m0_addr;
                rw       <= winner ? m1_rw    : m0_rw;
                data_in  <= winner ? m1_wdata : m0_wdata;
                in_valid <= 1'b1;
                owner    <= winner;
                m0_ready <= !winner;
                m1_ready <= winner;
            end
            if (accept) begin
                in_valid <= 1'b0;
                tmo_cnt  <= '0;
            end
            if (state == RD_WAIT && !rd_done && !rd_tmo) begin
                tmo_cnt <= tmo_cnt + 16'd1;
            end
            if (rd_done) begin
                if (owner) begin
                    m1_rdata  <= data_out;
                    m1_rvalid <= 1'b1;
                end else begin
                    m0_rdata  <= data_out;
                    m0_rvalid <= 1'b1;
                end
            end
            if (rd_tmo) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_arbiter
//  Purpose  : Randomized bench for sdram_arbiter. Two random requesters and a
//             behavioural controller (random busy, random read latency, stray
//             strobes, random resets) drive the DUT; a transaction-level model
//             predicts every output after each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int AW     = 25;
    localparam int DW     = 32;
    localparam int RD_TO  = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic          m0_rw = 1'b0, m1_rw = 1'b0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_valid = 1'b0, m1_valid = 1'b0;
    logic          m0_ready, m1_ready, m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] addr;
    logic          rw, in_valid, timeout_err;
    logic [DW-1:0] data_in;
    logic          busy = 1'b0;
    logic [DW-1:0] data_out = '0;
    logic          out_valid = 1'b0;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(RD_TO)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wdata(m0_wdata), .m0_valid(m0_valid),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wdata(m1_wdata), .m1_valid(m1_valid),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .addr(addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
        .busy(busy), .data_out(data_out), .out_valid(out_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus knobs
    int req_pct     = 0;
    int wr_only     = 0;
    int busy_pct    = 0;
    int lat_lo      = 0;
    int lat_hi      = 0;
    int stray_pct   = 0;
    int rst_permil  = 1000;
    int ret_cnt     = 0;

    // Transaction-level reference model: phase 0 = no command, 1 = command
    // presented to the controller, 2 = read awaiting data.
    int            phase = 0;
    bit            cur_port = 1'b0;
    logic [AW-1:0] cur_addr = '0;
    logic          cur_rw = 1'b0;
    logic [DW-1:0] cur_wdata = '0;
    int            waited = 0;
    bit            last = 1'b1;
    bit            err = 1'b0;
    logic [DW-1:0] exp_rdata [2];
    bit            exp_ready [2];
    bit            exp_rvalid [2];
    int            n_grants [2];
    int            n_tmo = 0;
    int            n_rd = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT just sampled.
    task automatic model_step();
        bit win;
        exp_ready  = '{1'b0, 1'b0};
        exp_rvalid = '{1'b0, 1'b0};
        if (!rst) begin
            phase = 0; last = 1'b1; err = 1'b0;
            cur_addr = '0; cur_rw = 1'b0; cur_wdata = '0;
            exp_rdata = '{32'd0, 32'd0};
        end else if (phase == 0) begin
            if (m0_valid || m1_valid) begin
`ifdef SDRAM_ARB_FIXED_PRIO_EN
                win = m0_valid ? 1'b0 : 1'b1;
`else
                if (m0_valid && m1_valid) win = (last == 1'b0);
                else                      win = m1_valid;
`endif
                cur_port  = win;
                cur_addr  = win ? m1_addr  : m0_addr;
                cur_rw    = win ? m1_rw    : m0_rw;
                cur_wdata = win ? m1_wdata : m0_wdata;
                exp_ready[win] = 1'b1;
                last = win;
                n_grants[win]++;
                phase = 1;
            end
        end else if (phase == 1) begin
            if (!busy) begin
                phase  = cur_rw ? 0 : 2;
                waited = 0;
            end
        end else begin
            if (out_valid) begin
                exp_rdata[cur_port]  = data_out;
                exp_rvalid[cur_port] = 1'b1;
                n_rd++;
                phase = 0;
            end else begin
                waited++;
                if (waited >= RD_TO) begin
                    err = 1'b1;
                    n_tmo++;
                    phase = 0;
                end
            end
        end
    endtask

    // One clock: edge, model update, compare, then drive the next inputs.
    task automatic cycle();
        bit acc;
        @(posedge clk);
        #1;
        model_step();
        check_eq("in_valid",    64'(in_valid),    64'(phase == 1));
        check_eq("addr",        64'(addr),        64'(cur_addr));
        check_eq("rw",          64'(rw),          64'(cur_rw));
        check_eq("data_in",     64'(data_in),     64'(cur_wdata));
        check_eq("m0_ready",    64'(m0_ready),    64'(exp_ready[0]));
        check_eq("m1_ready",    64'(m1_ready),    64'(exp_ready[1]));
        check_eq("m0_rvalid",   64'(m0_rvalid),   64'(exp_rvalid[0]));
        check_eq("m1_rvalid",   64'(m1_rvalid),   64'(exp_rvalid[1]));
        check_eq("m0_rdata",    64'(m0_rdata),    64'(exp_rdata[0]));
        check_eq("m1_rdata",    64'(m1_rdata),    64'(exp_rdata[1]));
        check_eq("timeout_err", 64'(timeout_err), 64'(err));

        // Requesters: hold until ready, then maybe issue a fresh request.
        if (m0_ready) m0_valid = 1'b0;
        if (m1_ready) m1_valid = 1'b0;
        if (!m0_valid && ($urandom % 100) < req_pct) begin
            m0_valid = 1'b1;
            m0_addr  = AW'($urandom);
            m0_rw    = wr_only ? 1'b1 : 1'($urandom);
            m0_wdata = $urandom;
        end
        if (!m1_valid && ($urandom % 100) < req_pct) begin
            m1_valid = 1'b1;
            m1_addr  = AW'($urandom);
            m1_rw    = wr_only ? 1'b1 : 1'($urandom);
            m1_wdata = $urandom;
        end

        // Controller: returns read data after a random latency.
        out_valid = 1'b0;
        data_out  = $urandom;
        if (ret_cnt > 0) begin
            ret_cnt--;
            if (ret_cnt == 0) out_valid = 1'b1;
        end else if (($urandom % 100) < stray_pct) begin
            out_valid = 1'b1;
        end
        busy = (($urandom % 100) < busy_pct);
        acc  = in_valid && !busy && rst;
        if (acc && !rw) ret_cnt = $urandom_range(lat_hi, lat_lo) + 1;

        rst = (($urandom % 1000) < rst_permil) ? 1'b0 : 1'b1;
    endtask

    initial begin
        exp_rdata  = '{32'd0, 32'd0};
        exp_ready  = '{1'b0, 1'b0};
        exp_rvalid = '{1'b0, 1'b0};
        n_grants   = '{0, 0};

        // Reset, then release.
        rst_permil = 1000;
        repeat (2) cycle();
        rst_permil = 0;
        cycle();

        // Both ports stream writes: arbitration order is exercised hard.
        req_pct = 100; wr_only = 1; busy_pct = 0;
        repeat (200) cycle();

        // Controller stalls for a long stretch with a command pending.
        busy_pct = 100;
        repeat (25) cycle();
        busy_pct = 0;
        repeat (10) cycle();

        // Mixed reads/writes, random stalls, latencies reaching past the timeout.
        req_pct = 50; wr_only = 0; busy_pct = 30;
        lat_lo = 0; lat_hi = 20; stray_pct = 3;
        repeat (1500) cycle();

        // Same traffic with occasional mid-operation resets.
        rst_permil = 15;
        repeat (800) cycle();
        rst_permil = 0;
        repeat (20) cycle();

        check_eq("saw_m0_grant", 64'(n_grants[0] > 0), 64'd1);
        check_eq("saw_m1_grant", 64'(n_grants[1] > 0), 64'd1);
        check_eq("saw_timeout",  64'(n_tmo > 0),       64'd1);
        check_eq("saw_rd_return", 64'(n_rd > 0),       64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
